// File: rtl/ttt_pkg.sv
// ttt_pkg
// Shared definitions for the tic-tac-toe controller slice.
//   - Cell codes stored in the board registers and shown on pos1..pos9.
//   - Controller state encoding.
//   - Table of the eight winning lines as board-index triples.
//     Board indices are 0..8, row-major. Index 0 is pos1 and index 8 is pos9.
//   - Small helper that returns the opponent of a player code.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    typedef enum logic [2:0] {
        ST_X_TURN = 3'd0,
        ST_O_TURN = 3'd1,
        ST_CHECK  = 3'd2,
        ST_WIN    = 3'd3,
        ST_DRAW   = 3'd4
    } state_e;

    localparam int NUM_LINES = 8;

    typedef logic [3:0] cell_idx_t;

    // Three rows, then three columns, then the two diagonals.
    localparam cell_idx_t WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [1:0] otherPlayer(input logic [1:0] player);
        return (player == CELL_X) ? CELL_O : CELL_X;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// ttt_line_check
// Purely combinational check for three in a row on the board.
// Ports:
//   cells_i    in   9x2  board cells, index 0 = pos1, row-major
//   win_o      out  1    some line holds three equal non-empty cells
//   win_code_o out  2    cell code that owns the line, CELL_EMPTY when there is no win
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0][1:0] cells_i,
    output logic            win_o,
    output logic [1:0]      win_code_o
);

    logic [1:0] cellA;
    logic [1:0] cellB;
    logic [1:0] cellC;

    // Walk the line table. Only one player can own a line on a legal board,
    // so reporting the first completed line is enough.
    always_comb begin
        win_o      = 1'b0;
        win_code_o = CELL_EMPTY;
        cellA      = CELL_EMPTY;
        cellB      = CELL_EMPTY;
        cellC      = CELL_EMPTY;
        for (int l = 0; l < NUM_LINES; l++) begin
            cellA = cells_i[WIN_LINES[l][0]];
            cellB = cells_i[WIN_LINES[l][1]];
            cellC = cells_i[WIN_LINES[l][2]];
            if (!win_o && (cellA != CELL_EMPTY) && (cellA == cellB) && (cellB == cellC)) begin
                win_o      = 1'b1;
                win_code_o = cellA;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl
// Tic-tac-toe sequencing controller. It owns the board registers and alternates
// X and O. It rejects illegal requests. After each accepted move it spends one
// CHECK cycle deciding between win, draw and the next turn. An idle player loses
// the turn after TIMEOUT_CYCLES cycles. Set TIMEOUT_CYCLES to 0 to disable this.
// Ports:
//   clk         in   1  system clock, rising edge
//   reset       in   1  synchronous active-high reset
//   new_game    in   1  pulse: clear the board and restart with X
//   move_valid  in   1  pulse: the current player requests move_pos
//   move_pos    in   4  requested cell 1..9, all other values are invalid
//   pos1..pos9  out  2  cell contents (00 empty, 01 X, 10 O)
//   turn        out  2  01 X to move, 10 O to move, 00 no move accepted
//   illegal     out  1  pulse: the last request was rejected
//   timeout     out  1  pulse: the turn was forfeited through inactivity
//   game_over   out  1  game is in WIN or DRAW
//   winner      out  2  winning player code, 00 otherwise
//   draw        out  1  board full with no line
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] turn,
    output logic       illegal,
    output logic       timeout,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    localparam bit             TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e           state_q,      state_d;
    logic [8:0][1:0]  cells_q,      cells_d;
    logic [1:0]       lastPlayer_q, lastPlayer_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [1:0]       turn_q,       turn_d;
    logic             illegal_q,    illegal_d;
    logic             timeout_q,    timeout_d;
    logic             gameOver_q,   gameOver_d;
    logic [1:0]       winner_q,     winner_d;
    logic             draw_q,       draw_d;

    logic             lineWin;
    logic [1:0]       lineCode;
    logic             boardFull;
    logic             moveHit;
    logic [1:0]       moveCell;
    logic             moveOk;
    logic [1:0]       curPlayer;

    ttt_line_check u_line_check (
        .cells_i    (cells_q),
        .win_o      (lineWin),
        .win_code_o (lineCode)
    );

    // Full board is checked only in CHECK, after any line win has been ruled out.
    always_comb begin
        boardFull = 1'b1;
        for (int i = 0; i < 9; i++) begin
            boardFull = boardFull & (cells_q[i][1] | cells_q[i][0]);
        end
    end

    // Decode the requested cell without indexing out of range.
    // Positions 0 and 10..15 never match, so moveHit stays low for them.
    always_comb begin
        moveHit  = 1'b0;
        moveCell = CELL_EMPTY;
        for (int i = 0; i < 9; i++) begin
            if (move_pos == 4'(i + 1)) begin
                moveHit  = 1'b1;
                moveCell = cells_q[i];
            end
        end
        moveOk    = move_valid && moveHit && (moveCell == CELL_EMPTY);
        curPlayer = (state_q == ST_O_TURN) ? CELL_O : CELL_X;
    end

    // Next-state and registered-output logic. new_game overrides everything that
    // the current state decides, and reset overrides new_game in the register block.
    always_comb begin
        state_d      = state_q;
        cells_d      = cells_q;
        lastPlayer_d = lastPlayer_q;
        cnt_d        = cnt_q;
        illegal_d    = 1'b0;
        timeout_d    = 1'b0;
        winner_d     = winner_q;
        draw_d       = draw_q;

        unique case (state_q)
            ST_X_TURN, ST_O_TURN: begin
                if (moveOk) begin
                    for (int i = 0; i < 9; i++) begin
                        if (move_pos == 4'(i + 1)) begin
                            cells_d[i] = curPlayer;
                        end
                    end
                    lastPlayer_d = curPlayer;
                    state_d      = ST_CHECK;
                    cnt_d        = '0;
                end else begin
                    // A rejected request still lets the idle counter run.
                    illegal_d = move_valid;
                    if (TO_EN && (cnt_q == TO_LAST)) begin
                        state_d   = (state_q == ST_X_TURN) ? ST_O_TURN : ST_X_TURN;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else if (TO_EN) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                // Requests here are dropped silently. The source retries them.
                cnt_d = '0;
                if (lineWin) begin
                    state_d  = ST_WIN;
                    winner_d = lastPlayer_q;
                end else if (boardFull) begin
                    state_d = ST_DRAW;
                    draw_d  = 1'b1;
                end else begin
                    state_d = (otherPlayer(lastPlayer_q) == CELL_O) ? ST_O_TURN : ST_X_TURN;
                end
            end
            ST_WIN, ST_DRAW: begin
                illegal_d = move_valid;
            end
            default: begin
                state_d = ST_X_TURN;
            end
        endcase

        if (new_game) begin
            state_d      = ST_X_TURN;
            cells_d      = '0;
            lastPlayer_d = CELL_EMPTY;
            cnt_d        = '0;
            illegal_d    = 1'b0;
            timeout_d    = 1'b0;
            winner_d     = CELL_EMPTY;
            draw_d       = 1'b0;
        end

        // Status outputs are registered copies of what the next state implies.
        unique case (state_d)
            ST_X_TURN: turn_d = CELL_X;
            ST_O_TURN: turn_d = CELL_O;
            default:   turn_d = CELL_EMPTY;
        endcase
        gameOver_d = (state_d == ST_WIN) || (state_d == ST_DRAW);
    end

    // State, board and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_X_TURN;
            cells_q      <= '0;
            lastPlayer_q <= CELL_EMPTY;
            cnt_q        <= '0;
            turn_q       <= CELL_X;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            gameOver_q   <= 1'b0;
            winner_q     <= CELL_EMPTY;
            draw_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cells_q      <= cells_d;
            lastPlayer_q <= lastPlayer_d;
            cnt_q        <= cnt_d;
            turn_q       <= turn_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
            gameOver_q   <= gameOver_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
        end
    end

    assign pos1      = cells_q[0];
    assign pos2      = cells_q[1];
    assign pos3      = cells_q[2];
    assign pos4      = cells_q[3];
    assign pos5      = cells_q[4];
    assign pos6      = cells_q[5];
    assign pos7      = cells_q[6];
    assign pos8      = cells_q[7];
    assign pos9      = cells_q[8];
    assign turn      = turn_q;
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign game_over = gameOver_q;
    assign winner    = winner_q;
    assign draw      = draw_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb_ttt_game_ctrl
// Scoreboard bench for ttt_game_ctrl. The driver steps a game-level reference
// model once per clock and queues the full output picture expected after that edge.
// The monitor pops one entry per clock and compares it with the DUT outputs.
// Directed scenarios come first, followed by randomised play.
module tb_ttt_game_ctrl;

    localparam int TO = 8;

    logic       clk;
    logic       reset;
    logic       new_game;
    logic       move_valid;
    logic [3:0] move_pos;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] turn;
    logic       illegal;
    logic       timeout;
    logic       game_over;
    logic [1:0] winner;
    logic       draw;

    ttt_game_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .pos1       (pos1),
        .pos2       (pos2),
        .pos3       (pos3),
        .pos4       (pos4),
        .pos5       (pos5),
        .pos6       (pos6),
        .pos7       (pos7),
        .pos8       (pos8),
        .pos9       (pos9),
        .turn       (turn),
        .illegal    (illegal),
        .timeout    (timeout),
        .game_over  (game_over),
        .winner     (winner),
        .draw       (draw)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    logic [25:0] expQ[$];
    string       tagQ[$];
    string       curTag = "reset";

    // Reference model state, kept at game level.
    // Players are 1 = X and 2 = O. pending means a move waits to be judged.
    int mBoard [9];
    int mPlayer, mLast, mWinner, mIdle;
    bit mPending, mDraw, mIllegal, mTimeout;

    // Output picture layout: {draw, winner, game_over, timeout, illegal, turn, pos9..pos1}
    function automatic logic [25:0] dutOutputs();
        return {draw, winner, game_over, timeout, illegal, turn,
                pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
    endfunction

    function automatic logic [25:0] modelOutputs();
        logic [25:0] v;
        bit over;
        over = (mWinner != 0) || mDraw;
        v = '0;
        for (int i = 0; i < 9; i++) v[2*i +: 2] = 2'(mBoard[i]);
        v[19:18] = (mPending || over) ? 2'b00 : 2'(mPlayer);
        v[20]    = mIllegal;
        v[21]    = mTimeout;
        v[22]    = over;
        v[24:23] = 2'(mWinner);
        v[25]    = mDraw;
        return v;
    endfunction

    function automatic bit sameLine(int a, int b, int c);
        return (mBoard[a] != 0) && (mBoard[a] == mBoard[b]) && (mBoard[b] == mBoard[c]);
    endfunction

    function automatic bit boardHasLine();
        bit hit = 0;
        for (int r = 0; r < 3; r++) hit |= sameLine(3*r, 3*r + 1, 3*r + 2);
        for (int c = 0; c < 3; c++) hit |= sameLine(c, c + 3, c + 6);
        hit |= sameLine(0, 4, 8);
        hit |= sameLine(2, 4, 6);
        return hit;
    endfunction

    function automatic bit boardFull();
        bit full = 1;
        for (int i = 0; i < 9; i++) if (mBoard[i] == 0) full = 0;
        return full;
    endfunction

    task automatic modelStep(input bit rst, input bit ng, input bit mv, input int pos);
        bit legal;
        mIllegal = 0;
        mTimeout = 0;
        if (rst || ng) begin
            for (int i = 0; i < 9; i++) mBoard[i] = 0;
            mPlayer = 1; mLast = 0; mPending = 0; mWinner = 0; mDraw = 0; mIdle = 0;
        end else if ((mWinner != 0) || mDraw) begin
            mIllegal = mv;
        end else if (mPending) begin
            mPending = 0;
            mIdle = 0;
            if (boardHasLine()) mWinner = mLast;
            else if (boardFull()) mDraw = 1;
            else mPlayer = 3 - mLast;
        end else begin
            legal = 0;
            if (mv && pos >= 1 && pos <= 9) legal = (mBoard[pos-1] == 0);
            if (legal) begin
                mBoard[pos-1] = mPlayer;
                mLast = mPlayer;
                mPending = 1;
                mIdle = 0;
            end else begin
                mIllegal = mv;
                if (mIdle == TO - 1) begin
                    mPlayer = 3 - mPlayer;
                    mTimeout = 1;
                    mIdle = 0;
                end else begin
                    mIdle++;
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one clock's worth of inputs and queue the expected post-edge outputs.
    task automatic applyStimulus(input bit rst, input bit ng, input bit mv, input logic [3:0] pos);
        @(negedge clk);
        reset      = rst;
        new_game   = ng;
        move_valid = mv;
        move_pos   = pos;
        modelStep(rst, ng, mv, int'(pos));
        expQ.push_back(modelOutputs());
        tagQ.push_back(curTag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'd0);
    endtask

    task automatic playMove(input logic [3:0] pos);
        applyStimulus(0, 0, 1, pos);
        applyStimulus(0, 0, 0, 4'd0);
    endtask

    task automatic startGame();
        applyStimulus(0, 1, 0, 4'd0);
    endtask

    // Monitor: one expected picture per clock, plus the invariants that must hold always.
    initial begin
        logic [25:0] got;
        logic [25:0] exp;
        string tag;
        bit any11;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                tag = tagQ.pop_front();
                got = dutOutputs();
                checkOutput({tag, "_outputs"}, 32'(got), 32'(exp));
                any11 = 0;
                for (int i = 0; i < 9; i++) if (got[2*i +: 2] == 2'b11) any11 = 1;
                checkOutput("no_cell_11", 32'(any11), 32'd0);
                checkOutput("game_over_equiv", 32'(game_over), 32'((winner != 2'b00) || draw));
            end
        end
    end

    initial begin
        int r;
        logic [8:0][3:0] seq;
        reset = 1'b1;
        new_game = 1'b0;
        move_valid = 1'b0;
        move_pos = 4'd0;

        curTag = "reset";
        applyStimulus(1, 0, 0, 4'd0);
        applyStimulus(1, 0, 0, 4'd0);
        applyStimulus(0, 0, 0, 4'd0);
        checkOutput("reset_state", 32'(dutOutputs()), 32'h0040000);

        // X takes the top row.
        curTag = "win_row";
        playMove(4'd1); playMove(4'd4); playMove(4'd2); playMove(4'd5); playMove(4'd3);
        idle(1);
        checkOutput("win_winner", 32'(winner), 32'(2'b01));
        checkOutput("win_game_over", 32'(game_over), 32'd1);
        checkOutput("win_turn", 32'(turn), 32'd0);
        applyStimulus(0, 0, 1, 4'd6);
        idle(1);
        checkOutput("win_then_illegal", 32'(illegal), 32'd1);
        checkOutput("win_board_held", 32'(pos6), 32'd0);

        // Full board with no line.
        curTag = "draw";
        startGame();
        seq = {4'd9, 4'd7, 4'd8, 4'd6, 4'd4, 4'd5, 4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 9; i++) playMove(seq[i]);
        idle(1);
        checkOutput("draw_flag", 32'(draw), 32'd1);
        checkOutput("draw_winner", 32'(winner), 32'd0);

        // Ninth move completes column 1,4,7: the win has priority over the draw.
        curTag = "win_ninth";
        startGame();
        seq = {4'd7, 4'd9, 4'd8, 4'd6, 4'd4, 4'd5, 4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 9; i++) playMove(seq[i]);
        idle(1);
        checkOutput("ninth_winner", 32'(winner), 32'(2'b01));
        checkOutput("ninth_draw", 32'(draw), 32'd0);

        // Illegal requests, and a request made during CHECK.
        curTag = "illegal";
        startGame();
        applyStimulus(0, 0, 1, 4'd0);
        idle(1);
        checkOutput("pos0_illegal", 32'(illegal), 32'd1);
        checkOutput("pos0_turn", 32'(turn), 32'(2'b01));
        applyStimulus(0, 0, 1, 4'd12);
        checkOutput("illegal_one_cycle", 32'(illegal), 32'd0);
        idle(1);
        checkOutput("pos12_illegal", 32'(illegal), 32'd1);
        checkOutput("pos12_board", 32'(dutOutputs() & 26'h003FFFF), 32'd0);
        playMove(4'd5);
        applyStimulus(0, 0, 1, 4'd5);
        idle(1);
        checkOutput("occupied_illegal", 32'(illegal), 32'd1);
        checkOutput("occupied_cell", 32'(pos5), 32'(2'b01));
        checkOutput("occupied_turn", 32'(turn), 32'(2'b10));
        applyStimulus(0, 0, 1, 4'd1);
        applyStimulus(0, 0, 1, 4'd2);
        idle(1);
        checkOutput("check_no_illegal", 32'(illegal), 32'd0);
        checkOutput("check_drop_cell", 32'(pos2), 32'd0);
        checkOutput("check_next_turn", 32'(turn), 32'(2'b01));

        // X stays idle until the turn is forfeited. O then moves on its expiry cycle.
        curTag = "timeout";
        startGame();
        idle(8);
        checkOutput("to_not_yet", 32'(timeout), 32'd0);
        idle(1);
        checkOutput("to_pulse", 32'(timeout), 32'd1);
        checkOutput("to_turn", 32'(turn), 32'(2'b10));
        idle(6);
        applyStimulus(0, 0, 1, 4'd5);
        idle(1);
        checkOutput("to_move_wins", 32'(timeout), 32'd0);
        checkOutput("to_move_cell", 32'(pos5), 32'(2'b10));
        idle(1);

        // new_game with a simultaneous move, then reset while in CHECK.
        curTag = "restart";
        startGame();
        playMove(4'd1);
        playMove(4'd2);
        applyStimulus(0, 1, 1, 4'd3);
        idle(1);
        checkOutput("ng_board", 32'(dutOutputs() & 26'h003FFFF), 32'd0);
        checkOutput("ng_turn", 32'(turn), 32'(2'b01));
        applyStimulus(0, 0, 1, 4'd5);
        applyStimulus(1, 0, 0, 4'd0);
        applyStimulus(0, 0, 0, 4'd0);
        checkOutput("reset_in_check", 32'(dutOutputs()), 32'h0040000);

        // Randomised play: mostly cell requests, with some junk positions and restarts.
        curTag = "random";
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0)
                applyStimulus(1, 0, 0, 4'd0);
            else if (r < 6)
                applyStimulus(0, 1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            else if (r < 100)
                applyStimulus(0, 0, 1, 4'($urandom_range(1, 9)));
            else if (r < 115)
                applyStimulus(0, 0, 1, 4'($urandom_range(0, 15)));
            else
                applyStimulus(0, 0, 0, 4'($urandom_range(0, 15)));
        end
        idle(1);

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
